sram_port_arbiter: RTL and testbench

- Shares port 0 (read/write) of one 32x512 core-local SRAM macro between two requesters: the owning core's local memory port and the Wishbone slave path used by the management host.
- Fixed core priority, with a starvation guard that forces a Wishbone grant after a bounded wait.
- Registered SRAM drive; one access in flight at a time.
- Instantiated once per core SRAM, between the core, the Wishbone interconnect and the macro.

---
 rtl/sram_port_arbiter_pkg.sv | 18 +
 rtl/sram_port_arbiter_if.sv | 41 ++++
 rtl/sram_port_arbiter_grant_select.sv | 46 ++++
 rtl/sram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port-0 arbiter.
package sram_port_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef enum logic {
    CORE = 1'b0,
    WB   = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus bundle: the Wishbone slave path and the core memory port.
// The arbiter takes the slave modport; requesters (or a bench) take master.
interface sram_port_arbiter_if #(
  parameter int ADDRESS_WIDTH = 9
);
  import sram_port_arbiter_pkg::*;

  // Wishbone slave path
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [MASK_W-1:0] wb_sel_i;
  logic [23:0]       wb_adr_i;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_o;
  logic [DATA_W-1:0] wb_dat_o;

  // Core local memory port
  logic                     core_req;
  logic                     core_we;
  logic [MASK_W-1:0]        core_byte_select;
  logic [ADDRESS_WIDTH-1:0] core_address;
  logic [DATA_W-1:0]        core_write_data;
  logic                     core_ack;
  logic [DATA_W-1:0]        core_read_data;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o,
    input  core_req, core_we, core_byte_select, core_address, core_write_data,
    output core_ack, core_read_data
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o,
    output core_req, core_we, core_byte_select, core_address, core_write_data,
    input  core_ack, core_read_data
  );

endinterface

// File: rtl/sram_port_arbiter_grant_select.sv
// Winner selection for the SRAM arbiter: core has fixed priority, but a
// Wishbone request that has lost MAX_WAIT arbitrations is forced to win.
module sram_grant_select
  import sram_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_idle,
  input  logic   i_core_req,
  input  logic   i_wb_req,
  output owner_e o_grant,
  output logic   o_forced
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [7:0] r_wait_cnt;

  // Pick the winner for this IDLE cycle.
  always_comb begin
    // NOTE: defaults at the top of always_comb keep every path assigned, so no latch is inferred.
    o_grant  = CORE;
    o_forced = 1'b0;
    if (i_wb_req && (!i_core_req || r_wait_cnt == WAIT_LIMIT)) begin
      o_grant  = WB;
      o_forced = i_core_req;
    end
  end

  // Count arbitrations the pending Wishbone request has lost to the core.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (i_idle) begin
      if (i_wb_req && o_grant == CORE) begin
        if (r_wait_cnt != WAIT_LIMIT) r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port 0 between the owning core and the Wishbone host path.
// One access in flight: IDLE (arbitrate, enable SRAM) -> ACCESS -> RESPOND (ack).
// Optional build macro SRAM_ARB_STATS_EN adds saturating grant counters.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int MAX_WAIT      = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  sram_port_arbiter_if.slave       bus,
  output logic                     sram_csb0,
  output logic                     sram_web0,
  output logic [MASK_W-1:0]        sram_wmask0,
  output logic [ADDRESS_WIDTH-1:0] sram_addr0,
  output logic [DATA_W-1:0]        sram_din0,
  input  logic [DATA_W-1:0]        sram_dout0
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]              stat_core_grants,
  output logic [15:0]              stat_wb_grants,
  output logic [15:0]              stat_forced_grants
`endif
);

  state_e r_state;
  owner_e r_owner;
  logic   r_we;

  logic                     w_wb_req;
  logic                     w_any_req;
  logic                     w_idle;
  owner_e                   w_grant;
  logic                     w_forced;
  logic [ADDRESS_WIDTH-1:0] w_wb_addr;
  logic                     w_unused_bits;

  assign w_wb_req  = bus.wb_cyc_i & bus.wb_stb_i;
  assign w_any_req = w_wb_req | bus.core_req;
  assign w_idle    = (r_state == IDLE);
  assign w_wb_addr = bus.wb_adr_i[ADDRESS_WIDTH+1:2];

  // Byte-offset and high address bits select nothing inside one macro.
  assign w_unused_bits = &{1'b0, bus.wb_adr_i[23:ADDRESS_WIDTH+2],
                           bus.wb_adr_i[1:0], w_forced};

  sram_grant_select #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant_select (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .i_idle     (w_idle),
    .i_core_req (bus.core_req),
    .i_wb_req   (w_wb_req),
    .o_grant    (w_grant),
    .o_forced   (w_forced)
  );

  // Access sequencer with registered SRAM drive and registered acks.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state             <= IDLE;
      r_owner             <= CORE;
      r_we                <= 1'b0;
      bus.wb_ack_o        <= 1'b0;
      bus.wb_dat_o        <= '0;
      bus.core_ack        <= 1'b0;
      bus.core_read_data  <= '0;
      sram_csb0           <= 1'b1;
      sram_web0           <= 1'b1;
      sram_wmask0         <= '0;
      sram_addr0          <= '0;
      sram_din0           <= '0;
    end else begin
      bus.wb_ack_o <= 1'b0;
      bus.core_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner   <= w_grant;
            sram_csb0 <= 1'b0;
            if (w_grant == WB) begin
              r_we        <= bus.wb_we_i;
              sram_web0   <= ~bus.wb_we_i;
              sram_wmask0 <= bus.wb_sel_i;
              sram_addr0  <= w_wb_addr;
              sram_din0   <= bus.wb_dat_i;
            end else begin
              r_we        <= bus.core_we;
              sram_web0   <= ~bus.core_we;
              sram_wmask0 <= bus.core_byte_select;
              sram_addr0  <= bus.core_address;
              sram_din0   <= bus.core_write_data;
            end
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          sram_csb0 <= 1'b1;
          sram_web0 <= 1'b1;
          r_state   <= RESPOND;
        end
        RESPOND: begin
          if (r_owner == WB) begin
            bus.wb_ack_o <= 1'b1;
            bus.wb_dat_o <= r_we ? '0 : sram_dout0;
          end else begin
            bus.core_ack       <= 1'b1;
            bus.core_read_data <= r_we ? '0 : sram_dout0;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_ARB_STATS_EN
  // Saturating grant statistics, counted at the arbitration point.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stat_core_grants   <= '0;
      stat_wb_grants     <= '0;
      stat_forced_grants <= '0;
    end else if (w_idle && w_any_req) begin
      if (w_grant == CORE) begin
        if (stat_core_grants != 16'hFFFF) stat_core_grants <= stat_core_grants + 16'd1;
      end else begin
        if (stat_wb_grants != 16'hFFFF) stat_wb_grants <= stat_wb_grants + 16'd1;
      end
      if (w_forced && stat_forced_grants != 16'hFFFF)
        stat_forced_grants <= stat_forced_grants + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM macro and a
// per-requester scoreboard of expected read data, checked on each ack.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDRESS_WIDTH(AW)) bus ();

  logic              sram_csb0;
  logic              sram_web0;
  logic [MASK_W-1:0] sram_wmask0;
  logic [AW-1:0]     sram_addr0;
  logic [DATA_W-1:0] sram_din0;
  logic [DATA_W-1:0] sram_dout0;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] stat_core_grants;
  logic [15:0] stat_wb_grants;
  logic [15:0] stat_forced_grants;
`endif

  sram_port_arbiter #(
    .ADDRESS_WIDTH (AW),
    .MAX_WAIT      (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .bus         (bus),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
`ifdef SRAM_ARB_STATS_EN
    ,
    .stat_core_grants   (stat_core_grants),
    .stat_wb_grants     (stat_wb_grants),
    .stat_forced_grants (stat_forced_grants)
`endif
  );

  // Behavioural 32x512 macro: byte-masked write, read data after the enable edge.
  logic [DATA_W-1:0] mem [512];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < MASK_W; b++)
          if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  exp_t core_q[$];
  exp_t wb_q[$];

  task automatic expect_core(input string tag, input logic [31:0] d);
    core_q.push_back('{tag, d});
  endtask

  task automatic expect_wb(input string tag, input logic [31:0] d);
    wb_q.push_back('{tag, d});
  endtask

  // Scoreboard: every ack pops one expected read-data value.
  always @(negedge clk) begin
    exp_t e;
    if (bus.core_ack !== 1'b0) begin
      if (core_q.size() == 0) check("core_spurious_ack", 32'(bus.core_ack), 32'd0);
      else begin
        e = core_q.pop_front();
        check(e.tag, bus.core_read_data, e.data);
      end
    end
    if (bus.wb_ack_o !== 1'b0) begin
      if (wb_q.size() == 0) check("wb_spurious_ack", 32'(bus.wb_ack_o), 32'd0);
      else begin
        e = wb_q.pop_front();
        check(e.tag, bus.wb_dat_o, e.data);
      end
    end
  end

  task automatic core_drive(input logic we, input logic [AW-1:0] addr,
                            input logic [31:0] data, input logic [3:0] mask);
    bus.core_req         = 1'b1;
    bus.core_we          = we;
    bus.core_address     = addr;
    bus.core_write_data  = data;
    bus.core_byte_select = mask;
  endtask

  task automatic wb_drive(input logic we, input logic [23:0] adr,
                          input logic [31:0] data, input logic [3:0] sel);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = data;
    bus.wb_sel_i = sel;
  endtask

  // Wait (bounded) for every pending request to be acked, dropping each
  // request in its ack cycle. Returns the negedge index of each ack, -1 if none.
  task automatic run_acks(input int limit, output int core_at, output int wb_at);
    bit core_pend;
    bit wb_pend;
    core_at   = -1;
    wb_at     = -1;
    core_pend = bus.core_req;
    wb_pend   = bus.wb_stb_i;
    for (int c = 1; c <= limit && (core_pend || wb_pend); c++) begin
      @(negedge clk);
      if (core_pend && bus.core_ack === 1'b1) begin
        core_at = c; core_pend = 1'b0; bus.core_req = 1'b0;
      end
      if (wb_pend && bus.wb_ack_o === 1'b1) begin
        wb_at = c; wb_pend = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      end
    end
    bus.core_req = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  initial begin
    int c_at;
    int w_at;
    int n_core;

    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_address = '0;
    bus.core_write_data = '0; bus.core_byte_select = '0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_wb_ack",    32'(bus.wb_ack_o), 32'd0);
    check("rst_core_ack",  32'(bus.core_ack), 32'd0);
    check("rst_wb_dat",    bus.wb_dat_o, 32'd0);
    check("rst_core_rd",   bus.core_read_data, 32'd0);
    check("rst_csb0",      32'(sram_csb0), 32'd1);
    check("rst_web0",      32'(sram_web0), 32'd1);
    check("rst_wmask0",    32'(sram_wmask0), 32'd0);
    check("rst_addr0",     32'(sram_addr0), 32'd0);
    check("rst_din0",      sram_din0, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Core write then read; ack registered on the second edge after sampling,
    // i.e. on the third negedge after the request is driven.
    core_drive(1'b1, 9'h005, 32'hDEADBEEF, 4'hF);
    expect_core("core_wr_rdata_zero", 32'd0);
    run_acks(20, c_at, w_at);
    check("core_wr_latency", 32'(c_at), 32'd3);
    core_drive(1'b0, 9'h005, 32'd0, 4'hF);
    expect_core("core_rd_0x005", 32'hDEADBEEF);
    run_acks(20, c_at, w_at);
    check("core_rd_latency", 32'(c_at), 32'd3);
    @(negedge clk);
    check("core_rdata_hold", bus.core_read_data, 32'hDEADBEEF);

    // Wishbone partial write over a full word
    wb_drive(1'b1, 24'h000010, 32'hFFFFFFFF, 4'hF);
    expect_wb("wb_wr_full_rdata_zero", 32'd0);
    run_acks(20, c_at, w_at);
    wb_drive(1'b1, 24'h000010, 32'h12345678, 4'h3);
    expect_wb("wb_wr_part_rdata_zero", 32'd0);
    run_acks(20, c_at, w_at);
    check("wb_wr_latency", 32'(w_at), 32'd3);
    wb_drive(1'b0, 24'h000010, 32'd0, 4'hF);
    expect_wb("wb_rd_merged", 32'hFFFF5678);
    run_acks(20, c_at, w_at);

    // All-zero mask write: access happens with wmask0=0 and leaves data intact
    wb_drive(1'b1, 24'h000010, 32'h00000000, 4'h0);
    expect_wb("wb_zero_mask_ack", 32'd0);
    @(negedge clk);
    check("zero_mask_csb0",   32'(sram_csb0), 32'd0);
    check("zero_mask_web0",   32'(sram_web0), 32'd0);
    check("zero_mask_wmask0", 32'(sram_wmask0), 32'd0);
    run_acks(20, c_at, w_at);
    wb_drive(1'b0, 24'h000010, 32'd0, 4'hF);
    expect_wb("wb_rd_after_zero_mask", 32'hFFFF5678);
    run_acks(20, c_at, w_at);

    // Simultaneous requests: core first, Wishbone on the following access
    core_drive(1'b1, 9'h030, 32'h0BADF00D, 4'hF);
    wb_drive(1'b1, 24'h0000C4, 32'h600DCAFE, 4'hF);
    expect_core("contend_core_wr", 32'd0);
    expect_wb("contend_wb_wr", 32'd0);
    run_acks(30, c_at, w_at);
    check("contend_core_first", 32'(c_at), 32'd3);
    check("contend_wb_second",  32'(w_at), 32'd6);
    core_drive(1'b0, 9'h031, 32'd0, 4'hF);
    expect_core("contend_core_reads_wb_data", 32'h600DCAFE);
    run_acks(20, c_at, w_at);
    wb_drive(1'b0, 24'h0000C0, 32'd0, 4'hF);
    expect_wb("contend_wb_reads_core_data", 32'h0BADF00D);
    run_acks(20, c_at, w_at);

    // Starvation guard: core held, Wishbone forced on the 9th arbitration
    core_drive(1'b0, 9'h005, 32'd0, 4'hF);
    wb_drive(1'b0, 24'h000010, 32'd0, 4'hF);
    for (int i = 0; i < 8; i++) expect_core("starve_core_rd", 32'hDEADBEEF);
    expect_wb("starve_wb_forced_rd", 32'hFFFF5678);
    n_core = 0;
    w_at   = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.core_ack === 1'b1) n_core++;
      if (bus.wb_ack_o === 1'b1) begin
        w_at = c;
        break;
      end
    end
    bus.core_req = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    check("starve_wb_ack_at",      32'(w_at), 32'd27);
    check("starve_core_wins",      32'(n_core), 32'd8);
`ifdef SRAM_ARB_STATS_EN
    check("stat_forced_after_starve", 32'(stat_forced_grants), 32'd1);
`endif
    @(negedge clk);

    // Reset during ACCESS: no ack, SRAM disabled, contents survive
    core_drive(1'b1, 9'h020, 32'hA5A5A5A5, 4'hF);
    expect_core("pre_abort_wr", 32'd0);
    run_acks(20, c_at, w_at);
    core_drive(1'b0, 9'h020, 32'd0, 4'hF);
    @(negedge clk);
    check("abort_csb0_active", 32'(sram_csb0), 32'd0);
    rst = 1'b1;
    bus.core_req = 1'b0;
    @(negedge clk);
    check("abort_csb0_idle",  32'(sram_csb0), 32'd1);
    check("abort_web0_idle",  32'(sram_web0), 32'd1);
    check("abort_core_ack",   32'(bus.core_ack), 32'd0);
    check("abort_core_rdata", bus.core_read_data, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_late_ack", 32'(bus.core_ack), 32'd0);
`ifdef SRAM_ARB_STATS_EN
    check("stat_forced_cleared", 32'(stat_forced_grants), 32'd0);
`endif
    core_drive(1'b0, 9'h020, 32'd0, 4'hF);
    expect_core("post_abort_rd", 32'hA5A5A5A5);
    run_acks(20, c_at, w_at);
    check("post_abort_latency", 32'(c_at), 32'd3);

    // Wishbone address wrap within the macro
    wb_drive(1'b1, 24'h0007FC, 32'hCAFE01FF, 4'hF);
    expect_wb("wrap_hi_wr", 32'd0);
    @(negedge clk);
    check("wrap_addr_0x7fc", 32'(sram_addr0), 32'h1FF);
    run_acks(20, c_at, w_at);
    wb_drive(1'b1, 24'h000800, 32'hCAFE0000, 4'hF);
    expect_wb("wrap_lo_wr", 32'd0);
    @(negedge clk);
    check("wrap_addr_0x800", 32'(sram_addr0), 32'h000);
    run_acks(20, c_at, w_at);
    core_drive(1'b0, 9'h1FF, 32'd0, 4'hF);
    expect_core("wrap_rd_1ff", 32'hCAFE01FF);
    run_acks(20, c_at, w_at);
    core_drive(1'b0, 9'h000, 32'd0, 4'hF);
    expect_core("wrap_rd_000", 32'hCAFE0000);
    run_acks(20, c_at, w_at);

    repeat (3) @(negedge clk);
    check("core_queue_drained", 32'(core_q.size()), 32'd0);
    check("wb_queue_drained",   32'(wb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
